instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Assembles RISC-V instruction words from a mnemonic/operand request and streams each word into byte-wide instruction memory at an auto-incrementing address. It produces exactly the opcode/func3/func7 encodings that the control path's ALU decoder consumes. It serves as the boot/program loader in front of the multi-cycle core's instruction memory and as the bench's program generator.

## Interface
- `ADDR_W`, default 32: memory address width.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `addr_load  in  1`: load the write pointer from `addr_in`; honoured only in IDLE.
- `addr_in  in  ADDR_W`: new base address.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: block can accept a request; high only in IDLE.
- `op  in  5`: mnemonic.
  - 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 xori, 7 ori, 8 slti.
  - 9 lw, 10 sw, 11 lui, 12 jalr.
  - 13 beq, 14 bne, 15 blt, 16 bge.
  - 17–31 illegal.
- `rd`, `rs1`, `rs2  in  5` each: register indices.
- `imm  in  32`: immediate. For lui it is the full value with bits [31:12] used; for branches it is the byte offset.
- `mem_we  out  1`: byte write strobe.
- `mem_addr  out  ADDR_W`: byte address.
- `mem_wdata  out  8`: byte data.
- `word_done  out  1`: one-cycle pulse coincident with the last byte write.
- `err  out  1`: one-cycle pulse on an illegal mnemonic.

## Operation
- Handshake: a request is accepted when `req_valid & req_ready`. Operands are sampled only on that edge.
- The encoded word is registered on acceptance.
- Encodings:
  - R, opcode 0110011: add f3=000/f7=0000000; sub f3=000/f7=0100000; and f3=111; or f3=110; slt f3=010.
  - I-arith, opcode 0010011: addi 000, xori 100, ori 110, slti 010; imm[11:0] goes to [31:20].
  - lw: opcode 0000011, f3=010. jalr: opcode 1100111, f3=000. Both are I-format.
  - sw: opcode 0100011, f3=010; imm[11:5]→[31:25], imm[4:0]→[11:7].
  - lui: opcode 0110111; imm[31:12]→[31:12].
  - Branch, opcode 1100011: beq 000, bne 001, blt 100, bge 101. imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7; imm[0] is ignored.
- Fields unused by a format are zero. Immediates are truncated to the field width without any range check.
- FSM states:
  - IDLE: on accept of a legal op → WRITE with byte count 0. On accept of an illegal op → ERR.
  - WRITE: emits byte k (bits [8k+7:8k], little-endian) at the pointer, then increments the pointer. After k=3 → IDLE.
  - ERR: pulses `err`, performs no write, → IDLE.
- Pointer:
  - Increments by 1 per byte written and wraps modulo 2^ADDR_W.
  - `addr_load` takes priority over accept in the same IDLE cycle: the pointer is loaded first and the request is accepted in that cycle, so the word goes to `addr_in`.
  - `addr_load` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, pointer 0, `req_ready`=1 (IDLE), and `mem_we`, `mem_addr`, `mem_wdata`, `word_done`, `err` all 0.
- Legal request accepted at edge 0:
  - `mem_we` is high during cycles 1–4, with addresses P..P+3.
  - `word_done` is high in cycle 4.
  - `req_ready` is low in cycles 1–4 and high again in cycle 5.
  - Sustained rate: 1 word per 5 cycles.
- Illegal request: `err` is high in cycle 1, `req_ready` is high again in cycle 2, and the pointer is unchanged.
- `mem_addr` and `mem_wdata` are 0 whenever `mem_we` is 0.
- Reset mid-WRITE aborts immediately. Bytes already written stay in memory, and no `word_done` is issued.

## Structure
- Shared package `rv_isa_pkg`, holding:
  - opcode constants (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_LUI, OP_JALR, OP_BRANCH);
  - func3/func7 constants;
  - the mnemonic enum.
- The ALU decoder shares the same package.
- Combinational sub-module `instr_word_builder` (op, rd, rs1, rs2, imm → word, illegal). The top level holds the FSM, byte counter and pointer.

## Test plan
- Load base 0x100, then request add x3,x1,x2 → word 0x002081B3. Bytes B3, 81, 20, 00 at 0x100–0x103 in cycles 1–4; `word_done` in cycle 4.
- sub x5,x6,x7 followed immediately by sw x2,8(x1), with `req_valid` held → words 0x407302B3 then 0x0020A423 at consecutive addresses, with `req_ready` low for 4 cycles between them.
- beq x1,x2,imm=-4 → 0xFE208EE3. lui x5,imm=0x12345000 → 0x123452B7.
- op=31 → `err` pulse in cycle 1, no `mem_we`, pointer unchanged, `req_ready` high in cycle 2.
- Load base 0xFFFFFFFE and encode addi x1,x0,1 (0x00100093) → bytes at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Assert `rst` after the second byte → all outputs 0 asynchronously, no `word_done`, pointer 0, `req_ready`=1 after release.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// Shared RISC-V ISA definitions: opcodes, func3/func7 codes, the loader
// mnemonic set and the field-packing helpers for each instruction format.
package rv_isa_pkg;

  // Major opcodes
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // func3 codes
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;

  // func7 codes
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // Mnemonics understood by the loader; encodings 17..31 are illegal
  typedef enum logic [4:0] {
    MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND  = 5'd2,  MN_OR   = 5'd3,
    MN_SLT  = 5'd4,  MN_ADDI = 5'd5,  MN_XORI = 5'd6,  MN_ORI  = 5'd7,
    MN_SLTI = 5'd8,  MN_LW   = 5'd9,  MN_SW   = 5'd10, MN_LUI  = 5'd11,
    MN_JALR = 5'd12, MN_BEQ  = 5'd13, MN_BNE  = 5'd14, MN_BLT  = 5'd15,
    MN_BGE  = 5'd16
  } mnemonic_e;

  // Loader FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ERR   = 2'd2
  } loader_state_e;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OP_RTYPE};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  // imm[0] is dropped: branch targets are always halfword aligned
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [31:0] imm);
    return {imm[31:12], rd, opc};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request and byte-write bus of the instruction loader. The master side
// issues requests and owns the memory; the slave side is the loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 32
);
  logic              addr_load;
  logic [ADDR_W-1:0] addr_in;
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              word_done;
  logic              err;

  modport master (
    output addr_load, addr_in, req_valid, op, rd, rs1, rs2, imm,
    input  req_ready, mem_we, mem_addr, mem_wdata, word_done, err
  );

  modport slave (
    input  addr_load, addr_in, req_valid, op, rd, rs1, rs2, imm,
    output req_ready, mem_we, mem_addr, mem_wdata, word_done, err
  );
endinterface

// File: rtl/instr_word_builder.sv
// Combinational encoder: mnemonic plus operands to a 32-bit RISC-V word.
// Fields a format does not use stay zero; unknown mnemonics flag illegal.
module instr_word_builder
  import rv_isa_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the format packer for the requested mnemonic
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    word    = '0;
    illegal = 1'b0;
    case (op)
      MN_ADD:  word = enc_r(F7_BASE, F3_ADD_SUB, rd, rs1, rs2);
      MN_SUB:  word = enc_r(F7_SUB,  F3_ADD_SUB, rd, rs1, rs2);
      MN_AND:  word = enc_r(F7_BASE, F3_AND,     rd, rs1, rs2);
      MN_OR:   word = enc_r(F7_BASE, F3_OR,      rd, rs1, rs2);
      MN_SLT:  word = enc_r(F7_BASE, F3_SLT,     rd, rs1, rs2);
      MN_ADDI: word = enc_i(OP_ITYPE, F3_ADD_SUB, rd, rs1, imm);
      MN_XORI: word = enc_i(OP_ITYPE, F3_XOR,     rd, rs1, imm);
      MN_ORI:  word = enc_i(OP_ITYPE, F3_OR,      rd, rs1, imm);
      MN_SLTI: word = enc_i(OP_ITYPE, F3_SLT,     rd, rs1, imm);
      MN_LW:   word = enc_i(OP_LOAD,  F3_WORD,    rd, rs1, imm);
      MN_JALR: word = enc_i(OP_JALR,  F3_JALR,    rd, rs1, imm);
      MN_SW:   word = enc_s(F3_WORD, rs1, rs2, imm);
      MN_LUI:  word = enc_u(OP_LUI, rd, imm);
      MN_BEQ:  word = enc_b(F3_BEQ, rs1, rs2, imm);
      MN_BNE:  word = enc_b(F3_BNE, rs1, rs2, imm);
      MN_BLT:  word = enc_b(F3_BLT, rs1, rs2, imm);
      MN_BGE:  word = enc_b(F3_BGE, rs1, rs2, imm);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts one instruction request at a time, encodes it and
// streams the word little-endian into byte-wide memory at an auto-incrementing
// pointer. All bus outputs are registered so the memory sees clean strobes.
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_encoder_loader_if.slave  bus
);

  loader_state_e     state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word_q;
  logic [2:0]        byte_idx;   // next byte to emit; 4 means all four are out

  logic [31:0]       word;
  logic              illegal;
  logic [ADDR_W-1:0] base;

  instr_word_builder u_builder (
    .op      (bus.op),
    .rd      (bus.rd),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .imm     (bus.imm),
    .word    (word),
    .illegal (illegal)
  );

  // A base load in the same IDLE cycle as an accept redirects that very word
  assign base          = bus.addr_load ? bus.addr_in : ptr;
  assign bus.req_ready = (state == S_IDLE);

  // Loader FSM, write pointer and registered memory-bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ptr           <= '0;
      word_q        <= '0;
      byte_idx      <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.word_done <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      bus.word_done <= 1'b0;
      bus.err       <= 1'b0;
      case (state)
        S_IDLE: begin
          ptr <= base;
          if (bus.req_valid) begin
            if (illegal) begin
              bus.err <= 1'b1;
              state   <= S_ERR;
            end else begin
              // Byte 0 goes out straight away so the word occupies cycles 1..4
              word_q        <= word;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= base;
              bus.mem_wdata <= word[7:0];
              ptr           <= base + ADDR_W'(1);
              byte_idx      <= 3'd1;
              state         <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (byte_idx == 3'd4) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            byte_idx      <= '0;
            state         <= S_IDLE;
          end else begin
            bus.mem_addr  <= ptr;
            bus.mem_wdata <= word_q[8*byte_idx[1:0] +: 8];
            bus.word_done <= (byte_idx == 3'd3);
            ptr           <= ptr + ADDR_W'(1);
            byte_idx      <= byte_idx + 3'd1;
          end
        end

        S_ERR: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: the driver pushes expected byte
// writes and error pulses, a negedge monitor pops and compares them.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_encoder_loader_if #(.ADDR_W(32)) bus ();

  instr_encoder_loader #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic        err_q[$];
  logic [31:0] model_ptr = '0;
  int          checks    = 0;
  int          errors    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the queue; idle bus must be zero
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {32'h0, bus.mem_addr}, 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte_addr", bus.mem_addr, e.addr);
          check("byte_data", bus.mem_wdata, e.data);
          check("word_done", bus.word_done, e.done);
        end
      end else begin
        check("idle_bus", {bus.mem_addr, bus.mem_wdata, bus.word_done}, '0);
      end
      if (bus.err) begin
        check("err_expected", err_q.size() != 0, 1);
        if (err_q.size() != 0) void'(err_q.pop_front());
      end
    end
  end

  // Drive one request, wait for acceptance, and queue its expected effects.
  // Entered and left on a falling edge; waited reports cycles spent stalled.
  task automatic issue(input logic [4:0] op_i, input logic [4:0] rd_i,
                       input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                       input logic [31:0] imm_i, input logic [31:0] exp_word,
                       input bit legal, input bit load, input logic [31:0] base,
                       input bit keep, input int nbytes, output int waited);
    bus.op        = op_i;
    bus.rd        = rd_i;
    bus.rs1       = rs1_i;
    bus.rs2       = rs2_i;
    bus.imm       = imm_i;
    bus.addr_load = load;
    bus.addr_in   = base;
    bus.req_valid = 1'b1;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("ready_timeout", 0, 1);
    if (load) model_ptr = base;
    if (legal) begin
      for (int k = 0; k < 4; k++) begin
        if (k < nbytes) exp_q.push_back('{model_ptr, exp_word[8*k +: 8], (k == 3)});
        model_ptr = model_ptr + 32'd1;
      end
    end else begin
      err_q.push_back(1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    bus.addr_load = 1'b0;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.addr_load = 1'b0;
    bus.addr_in   = '0;
    bus.req_valid = 1'b0;
    bus.op        = '0;
    bus.rd        = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.imm       = '0;

    // Reset state
    #12;
    check("reset_ready", bus.req_ready, 1);
    check("reset_outs", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.word_done, bus.err}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // add x3,x1,x2 at base 0x100
    issue(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1, 1, 32'h100, 0, 4, w);
    check("first_no_stall", w, 0);
    repeat (4) @(negedge clk);

    // sub x5,x6,x7 then sw x2,8(x1) back to back with req_valid held
    issue(5'd1, 5'd5, 5'd6, 5'd7, 32'd0, 32'h407302B3, 1, 0, 32'h0, 1, 4, w);
    issue(5'd10, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1, 0, 32'h0, 0, 4, w);
    check("b2b_ready_low_cycles", w, 4);
    repeat (4) @(negedge clk);

    // beq x1,x2,-4 and lui x5,0x12345000
    issue(5'd13, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE208EE3, 1, 0, 32'h0, 0, 4, w);
    issue(5'd11, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h123452B7, 1, 0, 32'h0, 0, 4, w);
    // lw x4,-8(x2) and bge x3,x4,16
    issue(5'd9, 5'd4, 5'd2, 5'd0, 32'hFFFF_FFF8, 32'hFF812203, 1, 0, 32'h0, 0, 4, w);
    issue(5'd16, 5'd0, 5'd3, 5'd4, 32'd16, 32'h0041D863, 1, 0, 32'h0, 0, 4, w);
    repeat (4) @(negedge clk);

    // Illegal op 31: err in cycle 1, ready back in cycle 2, pointer unchanged
    issue(5'd31, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0, 0, 0, 32'h0, 0, 0, w);
    check("err_pulse", bus.err, 1);
    check("err_ready_low", bus.req_ready, 0);
    check("err_no_write", bus.mem_we, 0);
    @(negedge clk);
    check("err_ready_back", bus.req_ready, 1);
    check("err_pulse_single", bus.err, 0);
    // Next word must land right where the previous one ended
    issue(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1, 0, 32'h0, 0, 4, w);
    repeat (4) @(negedge clk);

    // Pointer wrap: addi x1,x0,1 at 0xFFFFFFFE
    issue(5'd5, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1, 1, 32'hFFFF_FFFE, 0, 4, w);
    repeat (4) @(negedge clk);

    // Reset after the second byte of a word
    issue(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1, 1, 32'h40, 0, 2, w);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_outs", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.word_done, bus.err}, '0);
    check("abort_ready", bus.req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = '0;
    @(negedge clk);
    check("post_reset_ready", bus.req_ready, 1);
    // Pointer restarted at 0
    issue(5'd5, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1, 0, 32'h0, 0, 4, w);
    repeat (6) @(negedge clk);

    check("exp_queue_drained", exp_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
